com_uart_rx_os: RTL and testbench
=================================

# com_uart_rx_os

Oversampling UART receiver, the next generation of the communication block's baud-tick receiver. Runs on the system clock, qualifies the serial line with a one-cycle `sample_tick` at OVS×baud, and recovers 5–8 data bits with optional parity and 1–2 stop bits. It adds mid-bit sampling, false-start rejection, framing/parity/overrun reporting and a valid/ready output handshake toward the UART buffer.

## Interface
- `OVS`, default 16: sample ticks per bit; power of two, 8..64.
- `SYNC_STAGES`, default 2: `rx` synchroniser depth, ≥2.
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sample_tick` in 1: one-`clk`-wide pulse at OVS×baud rate.
- `rx` in 1: serial line, idle high, asynchronous to `clk`.
- `data_bit_config` in 2: data bits = 5 + value.
- `parity_bit_config` in 2: bit1 = parity enabled, bit0 = odd (1) / even (0).
- `stop_bit_config` in 1: 0 = one stop bit, 1 = two.
- `rx_data` out 8: received word, LSB-first on line, right-justified, unused MSBs 0.
- `rx_valid` out 1: word and flags available.
- `rx_ready` in 1: consumer accepts the word.
- `parity_err` out 1: parity mismatch for current word, valid with `rx_valid`.
- `frame_err` out 1: a stop bit sampled 0, valid with `rx_valid`.
- `overrun` out 1: one-`clk` pulse, a frame completed while `rx_valid` was high.
- `break_det` out 1: one-`clk` pulse, break condition (see Configuration).

## Operation
- `rx` passes through SYNC_STAGES flops; all FSM logic uses the synchronised value `rxs`.
- Config inputs are sampled at start-bit confirmation; changes mid-frame do not affect the current frame.
- The FSM advances only on `clk` edges with `sample_tick`=1; a 4-bit-or-wider tick counter `tcnt` counts 0..OVS-1.
- IDLE: wait for `rxs`=0; clear `tcnt`, go to START.
- START: at `tcnt`=OVS/2-1 sample `rxs`; if 1 → IDLE (false start, no output); if 0 → clear `tcnt`, go to DATA. All later samples land mid-bit.
- DATA: at `tcnt`=OVS-1 shift `rxs` into bit `bitcnt`, increment `bitcnt`; after 5+cfg bits → PARITY if enabled, else STOP1.
- PARITY: sample at mid-bit; `parity_err` = (XOR of data bits XOR sample) != odd-flag. → STOP1.
- STOP1: sample; 0 sets frame error. → STOP2 if two stop bits, else COMPLETE.
- STOP2: sample; 0 sets frame error. → COMPLETE.
- COMPLETE (same edge as last stop sample): if `rx_valid`=0 load `rx_data`, `parity_err`, `frame_err`, set `rx_valid`; else drop the frame, pulse `overrun`, keep held word unchanged.
- After a frame with frame error the FSM enters WAIT_HIGH and returns to IDLE only once `rxs`=1; otherwise directly to IDLE, ready for a start bit on the next tick.
- Handshake: `rx_valid` stays high and `rx_data`/flags stay stable until `rx_valid`&`rx_ready`; on that edge `rx_valid` clears. Load and accept on the same edge: accept clears, then load wins (`rx_valid` stays 1 with new word, no overrun).

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `break_det`=0, FSM=IDLE, synchroniser flops=1.
- Latency: `rx_valid` rises one `clk` after the `sample_tick` edge that samples the final stop bit, i.e. (OVS/2 + OVS×(1+N+P+S-1)) ticks after start detection + SYNC_STAGES clks.
- `rx_ready` may be tied high; then `rx_valid` is a one-`clk` pulse.
- Reset mid-frame: partial frame discarded, no output; after release receiver waits in IDLE.

## Configuration
- `COM_UART_RX_BREAK_EN` defined: a frame whose data bits, parity bit (if enabled) and first stop bit are all 0 pulses `break_det` for one `clk`, produces no `rx_valid`, no `overrun`, and enters WAIT_HIGH.
- Not defined: `break_det` tied 0; such a frame is delivered as `rx_data`=0 with `frame_err`=1.

## Test plan
- OVS=16, 8N1, send 0xA5, `rx_ready`=1 -> one `rx_valid` pulse, `rx_data`=0xA5, both errors 0.
- 7 bits, odd parity, 2 stop, send 0x3C with correct parity then wrong parity -> 0x3C/`parity_err`=0, then 0x3C/`parity_err`=1.
- 5N1 send 0x15 with stop bit forced 0, then idle high -> `rx_data`=0x15, `frame_err`=1; next frame 0x0A received clean.
- Low glitch of 4 ticks on idle line -> no `rx_valid`, FSM back to IDLE.
- `rx_ready`=0, send 0x11 then 0x22 -> `rx_data` holds 0x11, `overrun` pulses once; raise `rx_ready` -> `rx_valid` falls.
- Line held low 12 bit times (8N1) -> with macro `break_det` pulse, no `rx_valid`; without macro `rx_data`=0, `frame_err`=1; assert `rst_n` mid-frame -> all outputs at reset values.

Source files
------------

// File: rtl/com_uart_rx_os.sv
// Oversampling UART receiver: mid-bit sampling, false-start rejection, error flags, valid/ready output.
// Optional break detection enabled by defining COM_UART_RX_BREAK_EN.
module com_uart_rx_os #(
  parameter int unsigned OVS         = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_tick,
  input  logic       rx,
  input  logic [1:0] data_bit_config,
  input  logic [1:0] parity_bit_config,
  input  logic       stop_bit_config,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       break_det
);

  localparam int unsigned TW = ($clog2(OVS) > 4) ? $clog2(OVS) : 4;
  localparam logic [TW-1:0] MID  = TW'(OVS/2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT_HIGH
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic [7:0]             shreg_q, shreg_d;
  logic [1:0]             nbits_q, nbits_d;
  logic                   par_en_q, par_en_d;
  logic                   par_odd_q, par_odd_d;
  logic                   two_stop_q, two_stop_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   break_q, break_d;
  logic                   rxs;
  logic                   complete;
  logic                   done_ferr;
  logic                   break_hit;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], rx};
  assign rxs    = sync_q[SYNC_STAGES-1];

`ifdef COM_UART_RX_BREAK_EN
  logic par_bit_q, par_bit_d;
  // Break: every data bit, the parity bit (when present) and the first stop bit are low.
  assign break_hit = ~rxs & (shreg_q == '0) & ~(par_en_q & par_bit_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_bit_q <= 1'b0;
    else        par_bit_q <= par_bit_d;
  end
  always_comb begin
    par_bit_d = par_bit_q;
    if (sample_tick && state_q == S_PARITY && tcnt_q == LAST) par_bit_d = rxs;
  end
`else
  assign break_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    bitcnt_d     = bitcnt_q;
    shreg_d      = shreg_q;
    nbits_d      = nbits_q;
    par_en_d     = par_en_q;
    par_odd_d    = par_odd_q;
    two_stop_d   = two_stop_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
    break_d      = 1'b0;
    complete     = 1'b0;
    done_ferr    = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (sample_tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            tcnt_d  = '0;
            state_d = S_START;
          end
        end
        S_START: begin
          if (tcnt_q == MID) begin
            if (rxs) begin
              state_d = S_IDLE;
            end else begin
              tcnt_d     = '0;
              bitcnt_d   = '0;
              shreg_d    = '0;
              perr_d     = 1'b0;
              ferr_d     = 1'b0;
              nbits_d    = data_bit_config;
              par_en_d   = parity_bit_config[1];
              par_odd_d  = parity_bit_config[0];
              two_stop_d = stop_bit_config;
              state_d    = S_DATA;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tcnt_q == LAST) begin
            tcnt_d            = '0;
            shreg_d[bitcnt_q] = rxs;
            bitcnt_d          = bitcnt_q + 1'b1;
            if (bitcnt_q == 3'd4 + {1'b0, nbits_q})
              state_d = par_en_q ? S_PARITY : S_STOP1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (tcnt_q == LAST) begin
            tcnt_d  = '0;
            perr_d  = ((^shreg_q) ^ rxs) != par_odd_q;
            state_d = S_STOP1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        S_STOP1: begin
          if (tcnt_q == LAST) begin
            tcnt_d = '0;
            if (break_hit) begin
              break_d = 1'b1;
              state_d = S_WAIT_HIGH;
            end else if (two_stop_q) begin
              ferr_d  = ~rxs;
              state_d = S_STOP2;
            end else begin
              complete  = 1'b1;
              done_ferr = ~rxs;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        S_STOP2: begin
          if (tcnt_q == LAST) begin
            tcnt_d    = '0;
            complete  = 1'b1;
            done_ferr = ferr_q | ~rxs;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (rxs) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Completion shares the edge of the final stop sample; a same-edge accept frees the buffer.
    if (complete) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shreg_q;
        parity_err_d = perr_q;
        frame_err_d  = done_ferr;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
      state_d = done_ferr ? S_WAIT_HIGH : S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sync_q       <= '1;
      tcnt_q       <= '0;
      bitcnt_q     <= '0;
      shreg_q      <= '0;
      nbits_q      <= '0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      two_stop_q   <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      break_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      tcnt_q       <= tcnt_d;
      bitcnt_q     <= bitcnt_d;
      shreg_q      <= shreg_d;
      nbits_q      <= nbits_d;
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      two_stop_q   <= two_stop_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      break_q      <= break_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign break_det  = break_q;

endmodule

// File: tb/tb_com_uart_rx_os.sv
// Directed and randomized frames for com_uart_rx_os, checked against a frame-level reference model.
module tb_com_uart_rx_os;

  localparam int unsigned OVS   = 16;
  localparam int unsigned TDIV  = 2;
  localparam int unsigned BIT_T = OVS * TDIV;
  localparam int unsigned BOUND = 4 * BIT_T;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_tick;
  logic       rx;
  logic [1:0] data_bit_config;
  logic [1:0] parity_bit_config;
  logic       stop_bit_config;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       break_det;

  int checks = 0;
  int errors = 0;

  int acc_cnt = 0;
  int vcycles = 0;
  int ovr_cnt = 0;
  int brk_cnt = 0;
  logic [7:0] acc_data;
  logic       acc_pe, acc_fe;

  logic [7:0] exp_d;
  logic       exp_pe, exp_fe;

  com_uart_rx_os #(.OVS(OVS), .SYNC_STAGES(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .sample_tick       (sample_tick),
    .rx                (rx),
    .data_bit_config   (data_bit_config),
    .parity_bit_config (parity_bit_config),
    .stop_bit_config   (stop_bit_config),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_ready          (rx_ready),
    .parity_err        (parity_err),
    .frame_err         (frame_err),
    .overrun           (overrun),
    .break_det         (break_det)
  );

  always #5 clk = ~clk;

  initial begin
    int c;
    c = 0;
    sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      c = (c + 1) % TDIV;
      sample_tick = (c == 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rx_valid) vcycles++;
        if (rx_valid && rx_ready) begin
          acc_cnt++;
          acc_data = rx_data;
          acc_pe   = parity_err;
          acc_fe   = frame_err;
        end
        if (overrun)   ovr_cnt++;
        if (break_det) brk_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_time(input logic b);
    rx = b;
    clks(BIT_T);
  endtask

  // Reference model: builds the line waveform from the frame description and records the expected word.
  task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit podd,
                            input bit two, input bit bad_par, input bit bad_stop);
    logic [7:0] mask;
    logic       p;
    mask   = 8'((1 << nb) - 1);
    exp_d  = d & mask;
    exp_pe = pen && bad_par;
    exp_fe = bad_stop;
    p      = (^exp_d) ^ podd ^ bad_par;
    data_bit_config   = 2'(nb - 5);
    parity_bit_config = {pen, podd};
    stop_bit_config   = two;
    bit_time(1'b0);
    for (int i = 0; i < nb; i++) bit_time(exp_d[i]);
    if (pen) bit_time(p);
    bit_time(!bad_stop);
    if (two) bit_time(1'b1);
    bit_time(1'b1);
    bit_time(1'b1);
  endtask

  task automatic wait_valid(input string tag);
    int unsigned n;
    n = 0;
    while (rx_valid !== 1'b1 && n < BOUND) begin
      clks(1);
      n++;
    end
    chk({tag, "_valid"}, rx_valid, 1'b1);
  endtask

  task automatic check_held(input string tag);
    wait_valid(tag);
    chk({tag, "_data"}, rx_data, exp_d);
    chk({tag, "_perr"}, parity_err, exp_pe);
    chk({tag, "_ferr"}, frame_err, exp_fe);
  endtask

  task automatic accept(input string tag);
    rx_ready = 1'b1;
    clks(1);
    rx_ready = 1'b0;
    chk({tag, "_accept"}, rx_valid, 1'b0);
  endtask

  initial begin
    int a0, v0, o0, b0;
    logic [7:0] d;
    int nb;
    bit pen, podd, two, bp, bs;

    rst_n = 1'b0;
    rx = 1'b1;
    rx_ready = 1'b0;
    data_bit_config = 2'd3;
    parity_bit_config = 2'b00;
    stop_bit_config = 1'b0;
    clks(5);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_flags", {parity_err, frame_err, overrun, break_det}, 4'b0000);
    rst_n = 1'b1;
    clks(BIT_T);

    // 8N1 0xA5 with rx_ready tied high: a single one-cycle pulse
    rx_ready = 1'b1;
    a0 = acc_cnt; v0 = vcycles;
    send_frame(8'hA5, 8, 0, 0, 0, 0, 0);
    chk("a5_count", acc_cnt - a0, 1);
    chk("a5_pulse", vcycles - v0, 1);
    chk("a5_data", acc_data, 8'hA5);
    chk("a5_flags", {acc_pe, acc_fe}, 2'b00);
    rx_ready = 1'b0;

    // 7O2 good then bad parity
    send_frame(8'h3C, 7, 1, 1, 1, 0, 0);
    check_held("p_ok");
    accept("p_ok");
    send_frame(8'h3C, 7, 1, 1, 1, 1, 0);
    check_held("p_bad");
    chk("p_bad_pe1", parity_err, 1'b1);
    accept("p_bad");

    // 5N1 framing error, then a clean frame
    send_frame(8'h15, 5, 0, 0, 0, 0, 1);
    check_held("fe");
    accept("fe");
    send_frame(8'h0A, 5, 0, 0, 0, 0, 0);
    check_held("after_fe");
    accept("after_fe");

    // Short low glitch must not start a frame
    v0 = vcycles;
    rx = 1'b0;
    clks(4 * TDIV);
    rx = 1'b1;
    clks(2 * BIT_T);
    chk("glitch_none", vcycles - v0, 0);
    chk("glitch_valid", rx_valid, 1'b0);
    send_frame(8'h66, 8, 0, 0, 0, 0, 0);
    check_held("post_glitch");
    accept("post_glitch");

    // Overrun: second frame dropped while first is held
    o0 = ovr_cnt;
    send_frame(8'h11, 8, 0, 0, 0, 0, 0);
    send_frame(8'h22, 8, 0, 0, 0, 0, 0);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_valid", rx_valid, 1'b1);
    chk("ovr_pulse", ovr_cnt - o0, 1);
    accept("ovr");
    chk("ovr_acc_data", acc_data, 8'h11);

    // Line held low for 12 bit times in 8N1
    data_bit_config = 2'd3;
    parity_bit_config = 2'b00;
    stop_bit_config = 1'b0;
    v0 = vcycles; b0 = brk_cnt; o0 = ovr_cnt;
    rx = 1'b0;
    clks(12 * BIT_T);
    rx = 1'b1;
    clks(2 * BIT_T);
`ifdef COM_UART_RX_BREAK_EN
    chk("brk_pulse", brk_cnt - b0, 1);
    chk("brk_novalid", vcycles - v0, 0);
    chk("brk_noovr", ovr_cnt - o0, 0);
`else
    chk("brk_tied", brk_cnt - b0, 0);
    exp_d = 8'h00; exp_pe = 1'b0; exp_fe = 1'b1;
    check_held("brk_word");
    accept("brk_word");
`endif

    // Reset mid-frame while a word is held
    send_frame(8'h5A, 8, 0, 0, 0, 0, 0);
    check_held("pre_rst");
    a0 = acc_cnt;
    rx = 1'b0;
    clks(3 * BIT_T);
    rst_n = 1'b0;
    clks(2);
    chk("mid_rst_data", rx_data, 8'h00);
    chk("mid_rst_valid", rx_valid, 1'b0);
    chk("mid_rst_flags", {parity_err, frame_err, overrun, break_det}, 4'b0000);
    rx = 1'b1;
    clks(2);
    rst_n = 1'b1;
    clks(3 * BIT_T);
    chk("post_rst_valid", rx_valid, 1'b0);
    chk("post_rst_acc", acc_cnt - a0, 0);

    // Randomized frames against the reference model
    for (int k = 0; k < 10; k++) begin
      nb   = 5 + int'($urandom_range(0, 3));
      pen  = bit'($urandom_range(0, 1));
      podd = bit'($urandom_range(0, 1));
      two  = bit'($urandom_range(0, 1));
      bp   = pen && ($urandom_range(0, 3) == 0);
      bs   = ($urandom_range(0, 4) == 0);
      d    = 8'($urandom);
      if (bs && ((d & 8'((1 << nb) - 1)) == 8'h00)) d = 8'h01;
      send_frame(d, nb, pen, podd, two, bp, bs);
      check_held("rand");
      accept("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: observed running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
